display7_scan: RTL and testbench
================================

Name: display7_scan

Overview:
- Parametrised successor to the parallel per-digit 7-segment decoder.
- Drives NUM_DIGITS common-anode digits through one shared segment bus using time-multiplexed scanning.
- Adds input snapshot on load, leading-zero blanking, per-digit blink, per-digit decimal point, and a defined blank state when disabled.
- Sits between the stopwatch BCD counters and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of BCD digits scanned (≥2).
- SCAN_DIV, 50000, clk cycles per digit slot (≥1; 1 = advance every cycle).
- BLINK_DIV, 250, scan ticks per blink half-period (≥1).
- AN_ACTIVE_LOW, 1, 1 = anode enables active-low, 0 = active-high.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits  in  4*NUM_DIGITS  BCD digits; digit i = bits [4i+3:4i]; digit 0 is least significant.
- load  in  1  when high at a clk edge, digits, dp_mask and blink_mask are captured into the snapshot.
- dp_mask  in  NUM_DIGITS  decimal point on for digit i when bit i = 1.
- blink_mask  in  NUM_DIGITS  digit i blinks when bit i = 1.
- blank_lz  in  1  leading-zero blanking enable (live, not snapshotted).
- displayativo  in  1  display enable (live).
- seg  out  7  segments {g,f,e,d,c,b,a}; active-low (0 = lit).
- dp  out  1  decimal point; active-low.
- an  out  NUM_DIGITS  one-hot digit enable; polarity set by AN_ACTIVE_LOW.

Behaviour:
- Reset (synchronous, active-high):
  - prescaler = 0, digit index = 0, blink counter = 0, blink phase = ON.
  - Snapshot registers = 0.
  - seg = 7'b1111111, dp = 1, all an inactive.
  - reset has priority over load, tick and blink updates.
  - Asserting reset mid-scan returns all state to these values at the next edge.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - scan tick = prescaler at SCAN_DIV-1.
  - On a tick, digit index advances by 1; NUM_DIGITS-1 wraps to 0.
- Blink:
  - Blink counter counts scan ticks 0..BLINK_DIV-1.
  - On a tick at BLINK_DIV-1: blink phase toggles and the counter returns to 0.
- Snapshot:
  - load at edge k updates the snapshot at edge k.
  - Outputs reflect the new values from edge k+1.
  - load and tick on the same edge: both take effect; no priority conflict.
- Output stage (all outputs registered; computed from current registers and live inputs):
  - Selected digit s = current index.
  - Decode table, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10–15 decode to 1111111 (blank).
  - Leading-zero blank: digit s blanked if blank_lz = 1, s ≠ 0, and every snapshot digit from s to NUM_DIGITS-1 is 0.
  - Digit 0 is never blanked by this rule.
  - Blink blank: digit s blanked if blink_mask[s] = 1 and blink phase = OFF.
  - Blanked digit: seg = 1111111, dp = 1, an for s is still asserted. This keeps scan brightness uniform.
  - Not blanked: seg = decode(snapshot digit s); dp = ~dp_mask[s]. dp is not suppressed by invalid codes.
  - displayativo = 0 sampled at edge k: from edge k, seg = 1111111, dp = 1, all an inactive.
  - Prescaler, index and blink continue counting while disabled.
  - Re-enable resumes at the current index; no glitch digit.
- Latency: index change at edge k appears on an/seg at edge k+1. an and seg always switch on the same edge.
- Exactly one an bit is active at any time when enabled and not in reset.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2):
1. Reset held 3 cycles, then released → seg=1111111, dp=1, an=4'b1111 during reset. First an=4'b1110 appears 1 cycle after release.
2. digits=16'h1234, load pulse, enable=1 → scan order:
   - an=1110 with seg=0011001 (4)
   - an=1101 with seg=0110000 (3)
   - an=1011 with seg=0100100 (2)
   - an=0111 with seg=1111001 (1)
   - Each slot lasts 4 cycles; wraps back to 1110.
3. digits=16'h0050, blank_lz=1 → digits 3 and 2 show 1111111; digit 1 shows 5 (0010010); digit 0 shows 0 (1000000). digits=16'h0000 → only digit 0 lit, showing 0.
4. digits=16'h00A9, blank_lz=0 → digit 1 (code A) shows 1111111; digit 0 shows 9 (0010000). Change digits with no load → display unchanged.
5. blink_mask=4'b0001, dp_mask=4'b0010 → digit 0 alternates lit/blank every 2 scan ticks (8 cycles). dp=0 only in the digit-1 slot.
6. displayativo dropped mid-slot → next edge gives an=1111, seg=1111111. Restored → scan resumes at the index it reached meanwhile. Reset asserted mid-scan → index returns to 0.

Source files
------------

// File: rtl/display7_scan.sv
// Time-multiplexed 7-segment driver: NUM_DIGITS common-anode digits share one segment bus.
// Inputs are snapshotted on load. Leading-zero blanking, per-digit blink and dp, and a blank state when disabled.
module display7_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int BLINK_DIV     = 250,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  input  logic                    displayativo,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [PW-1:0]             presc;
  logic [IW-1:0]             idx;
  logic [BW-1:0]             bcnt;
  logic                      phase_on;
  logic [4*NUM_DIGITS-1:0]   snap_digits;
  logic [NUM_DIGITS-1:0]     snap_dp;
  logic [NUM_DIGITS-1:0]     snap_blink;

  logic                      tick;
  logic [NUM_DIGITS:0]       zero_from;
  logic [NUM_DIGITS-1:0]     sel_oh;
  logic [3:0]                code;
  logic                      cur_dp;
  logic                      blank;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign tick = (presc == PMAX);

  // zero_from[i] is set when snapshot digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      zero_from[i] = zero_from[i+1] & (snap_digits[4*i +: 4] == 4'd0);
  end

  always_comb begin
    sel_oh = '0;
    code   = '0;
    cur_dp = 1'b0;
    blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_oh[i] = 1'b1;
        code      = snap_digits[4*i +: 4];
        cur_dp    = snap_dp[i];
        blank     = (blank_lz && (i != 0) && zero_from[i]) ||
                    (snap_blink[i] && !phase_on);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc       <= '0;
      idx         <= '0;
      bcnt        <= '0;
      phase_on    <= 1'b1;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blink  <= '0;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      an          <= AN_OFF;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= (idx == IMAX) ? '0 : idx + 1'b1;
        if (bcnt == BMAX) begin
          bcnt     <= '0;
          phase_on <= ~phase_on;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
      if (load) begin
        snap_digits <= digits;
        snap_dp     <= dp_mask;
        snap_blink  <= blink_mask;
      end
      // Outputs use pre-edge state so an and seg always move together.
      if (!displayativo) begin
        seg <= 7'b1111111;
        dp  <= 1'b1;
        an  <= AN_OFF;
      end else begin
        seg <= blank ? 7'b1111111 : decode(code);
        dp  <= blank ? 1'b1 : ~cur_dp;
        an  <= sel_oh ^ AN_OFF;
      end
    end
  end
endmodule

// File: tb/tb_display7_scan.sv
// Directed bench for display7_scan with NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
module tb_display7_scan;
  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic        load;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic        displayativo;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  display7_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digits(digits), .load(load), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .blank_lz(blank_lz), .displayativo(displayativo),
    .seg(seg), .dp(dp), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n = number of edges since reset release, minus one (edge E0 gives n=0)
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) cyc();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; digits = '0; dp_mask = '0; blink_mask = '0;
    blank_lz = 1'b0; displayativo = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp", dp, 1'b1);
    chk("rst_an", an, 4'b1111);

    reset = 1'b0; n = -1; cyc();
    chk("rel_an", an, 4'b1110);
    chk("rel_seg", seg, 7'b1000000);

    digits = 16'h1234; load = 1'b1; cyc(); load = 1'b0;
    chk("load_lat_seg", seg, 7'b1000000);
    run_to(2);  chk("s0_an", an, 4'b1110); chk("s0_seg", seg, 7'b0011001);
    chk("s0_dp", dp, 1'b1);
    run_to(7);  chk("s1_an", an, 4'b1101); chk("s1_seg", seg, 7'b0110000);
    run_to(8);  chk("s2_an", an, 4'b1011); chk("s2_seg", seg, 7'b0100100);
    run_to(12); chk("s3_an", an, 4'b0111); chk("s3_seg", seg, 7'b1111001);
    run_to(16); chk("wrap_an", an, 4'b1110); chk("wrap_seg", seg, 7'b0011001);

    digits = 16'h0050; blank_lz = 1'b1; load = 1'b1; cyc(); load = 1'b0;
    run_to(20); chk("lz_d1_an", an, 4'b1101); chk("lz_d1_seg", seg, 7'b0010010);
    run_to(24); chk("lz_d2_an", an, 4'b1011); chk("lz_d2_seg", seg, 7'b1111111);
    run_to(28); chk("lz_d3_an", an, 4'b0111); chk("lz_d3_seg", seg, 7'b1111111);
    run_to(32); chk("lz_d0_seg", seg, 7'b1000000);

    digits = 16'h0000; load = 1'b1; cyc(); load = 1'b0;
    run_to(36); chk("z_d1_an", an, 4'b1101); chk("z_d1_seg", seg, 7'b1111111);
    run_to(44); chk("z_d3_seg", seg, 7'b1111111);
    run_to(48); chk("z_d0_an", an, 4'b1110); chk("z_d0_seg", seg, 7'b1000000);

    digits = 16'h00A9; blank_lz = 1'b0; load = 1'b1; cyc(); load = 1'b0;
    run_to(52); chk("inv_d1_seg", seg, 7'b1111111);
    run_to(56); chk("nolz_d2_seg", seg, 7'b1000000);
    run_to(64); chk("d9_seg", seg, 7'b0010000);
    digits = 16'h1111;
    run_to(68); chk("hold_d1_seg", seg, 7'b1111111);
    run_to(80); chk("hold_d0_seg", seg, 7'b0010000);

    digits = 16'h00A9; dp_mask = 4'b0110; blink_mask = 4'b0101;
    load = 1'b1; cyc(); load = 1'b0;
    run_to(84); chk("dp_d1_an", an, 4'b1101); chk("dp_d1_seg", seg, 7'b1111111);
    chk("dp_d1_dp", dp, 1'b0);
    run_to(88); chk("blk_d2_an", an, 4'b1011); chk("blk_d2_seg", seg, 7'b1111111);
    chk("blk_d2_dp", dp, 1'b1);
    run_to(92); chk("d3_seg", seg, 7'b1000000); chk("d3_dp", dp, 1'b1);
    run_to(96); chk("blk_d0_seg", seg, 7'b0010000); chk("blk_d0_dp", dp, 1'b1);

    run_to(98); displayativo = 1'b0; cyc();
    chk("dis_an", an, 4'b1111); chk("dis_seg", seg, 7'b1111111); chk("dis_dp", dp, 1'b1);
    run_to(116); chk("dis_hold_an", an, 4'b1111);
    displayativo = 1'b1; cyc();
    chk("reen_an", an, 4'b1101); chk("reen_seg", seg, 7'b1111111); chk("reen_dp", dp, 1'b0);

    cyc(); reset = 1'b1; cyc();
    chk("mid_rst_an", an, 4'b1111); chk("mid_rst_seg", seg, 7'b1111111);
    reset = 1'b0; cyc();
    chk("post_rst_an", an, 4'b1110); chk("post_rst_seg", seg, 7'b1000000);
    repeat (3) cyc();
    chk("post_rst_slot_an", an, 4'b1110);
    cyc();
    chk("post_rst_next_an", an, 4'b1101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
